uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular-buffer FIFO. Frames are sent back-to-back with no idle gap.
// Frame format and baud divisor are fixed at elaboration time.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLKS_PER_BIT);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_next;

  logic tick;
  logic stop_done;
  logic pop;
  logic push;

  assign tick      = (div_cnt == DIV_LAST);
  assign stop_done = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);
  assign pop       = (fifo_count != '0) && ((state == S_IDLE) || stop_done);
  // Acceptance depends only on the registered count, never on a same-cycle pop.
  assign push      = wr_en && (fifo_count < DEPTH);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + 1'b1;
    end else if (!push && pop) begin
      count_next = fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      full       <= (count_next == DEPTH);
      overflow   <= wr_en && !push;
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define what is valid.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      // NOTE: non-blocking updates; a later assignment in a branch overrides this default.
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= ^mem[rd_ptr];
            bit_cnt <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= S_START;
          end else begin
            tx      <= 1'b1;
            tx_busy <= (count_next != '0);
          end
        end
        S_START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= (PARITY == 2) ? ~par_bit : par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (bit_cnt != STOP_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (pop) begin
              // Chain straight into the next start bit so back-to-back frames have no gap.
              shreg   <= mem[rd_ptr];
              par_bit <= ^mem[rd_ptr];
              bit_cnt <= '0;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              tx      <= 1'b1;
              tx_busy <= (count_next != '0);
              state   <= S_IDLE;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          tx      <= 1'b1;
          div_cnt <= '0;
          bit_cnt <= '0;
          tx_busy <= (count_next != '0);
        end
      endcase
    end
  end

endmodule
